// File: rtl/cp0.sv
// cp0: coprocessor-0 exception and interrupt controller at the M stage.
// Decides when fetch is redirected to the handler or back to EPC on eret,
// and holds the SR, Cause, EPC and PRId registers for mfc0/mtc0.
module cp0 #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
    parameter logic [31:0] PRID_VALUE   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic [31:0] pc_m,
    input  logic        valid_m,
    input  logic        bd_m,
    input  logic [4:0]  exc_code_m,
    input  logic        eret_m,
    input  logic [5:0]  hw_int,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        if_handler,
    output logic [31:0] handler_pc,
    output logic [31:0] epc
);

    // SR fields
    logic [5:0]  im;
    logic        exl;
    logic        ie;

    // Cause fields
    logic        bd;
    logic [5:0]  ip;
    logic [4:0]  exc_code;

    // EPC storage; the low two bits are kept at zero by every writer
    logic [31:0] epc_reg;

    // Request terms
    logic        int_req;
    logic        exc_req;
    logic        ret_req;
    logic        take_req;
    logic [31:0] victim_pc;

    // Derive the request terms from the M-stage inputs and current state
    always_comb begin
        int_req   = valid_m & ie & ~exl & (|(hw_int & im));
        exc_req   = valid_m & (exc_code_m != 5'd0);
        ret_req   = valid_m & eret_m & ~exc_req;
        take_req  = int_req | exc_req;
        victim_pc = bd_m ? (pc_m - 32'd4) : pc_m;
    end

    // Mealy redirect: reset suppresses it, handler entry beats eret
    always_comb begin
        if_handler = 1'b0;
        handler_pc = HANDLER_ADDR;
        if (!Reset) begin
            if (take_req) begin
                if_handler = 1'b1;
                handler_pc = HANDLER_ADDR;
            end else if (ret_req) begin
                if_handler = 1'b1;
                handler_pc = epc_reg;
            end
        end
    end

    // Register state: reset, then exception/interrupt, eret, mtc0 in priority order
    always_ff @(posedge clk) begin
        if (Reset) begin
            im       <= 6'd0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            bd       <= 1'b0;
            ip       <= 6'd0;
            exc_code <= 5'd0;
            epc_reg  <= 32'd0;
        end else begin
            ip <= hw_int;
            if (take_req) begin
                if (!exl) begin
                    epc_reg <= {victim_pc[31:2], 2'b00};
                    bd      <= bd_m;
                end
                exc_code <= int_req ? 5'd0 : exc_code_m;
                exl      <= 1'b1;
            end else if (ret_req) begin
                exl <= 1'b0;
            end else if (we) begin
                case (addr)
                    5'd12: begin
                        im  <= wdata[15:10];
                        exl <= wdata[1];
                        ie  <= wdata[0];
                    end
                    5'd14: epc_reg <= {wdata[31:2], 2'b00};
                    default: ;
                endcase
            end
        end
    end

    // mfc0 read mux over pre-edge register values
    always_comb begin
        rdata = 32'd0;
        case (addr)
            5'd12: rdata = {16'd0, im, 8'd0, exl, ie};
            5'd13: rdata = {bd, 15'd0, ip, 3'd0, exc_code, 2'd0};
            5'd14: rdata = epc_reg;
            5'd15: rdata = PRID_VALUE;
            default: rdata = 32'd0;
        endcase
    end

    assign epc = epc_reg;

endmodule

// File: tb/tb_cp0.sv
// tb_cp0: directed walk through the main cp0 scenarios followed by random
// stimulus, all checked against a word-level reference model of the registers.
module tb_cp0;

    localparam logic [31:0] HANDLER = 32'h0000_4180;
    localparam logic [31:0] PRID    = 32'hCAFE_0001;

    logic        clk;
    logic        reset;
    logic [31:0] pcM;
    logic        validM;
    logic        bdM;
    logic [4:0]  excCodeM;
    logic        eretM;
    logic [5:0]  hwInt;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ifHandler;
    logic [31:0] handlerPc;
    logic [31:0] epc;

    int checkCount;
    int errorCount;

    // Reference model state kept as whole architectural register words
    logic [31:0] mSr;
    logic [31:0] mCause;
    logic [31:0] mEpc;

    cp0 #(.HANDLER_ADDR(HANDLER), .PRID_VALUE(PRID)) dut (
        .clk(clk),
        .Reset(reset),
        .pc_m(pcM),
        .valid_m(validM),
        .bd_m(bdM),
        .exc_code_m(excCodeM),
        .eret_m(eretM),
        .hw_int(hwInt),
        .we(we),
        .addr(addr),
        .wdata(wdata),
        .rdata(rdata),
        .if_handler(ifHandler),
        .handler_pc(handlerPc),
        .epc(epc)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic v, input logic [31:0] pc, input logic b,
                                 input logic [4:0] code, input logic er, input logic [5:0] hw,
                                 input logic w, input logic [4:0] a, input logic [31:0] d);
        reset    = rst;
        validM   = v;
        pcM      = pc;
        bdM      = b;
        excCodeM = code;
        eretM    = er;
        hwInt    = hw;
        we       = w;
        addr     = a;
        wdata    = d;
    endtask

    function automatic logic modelInt();
        return validM && mSr[0] && !mSr[1] && ((hwInt & mSr[15:10]) != 6'd0);
    endfunction

    function automatic logic modelExc();
        return validM && (excCodeM != 5'd0);
    endfunction

    function automatic logic modelRet();
        return validM && eretM && !modelExc();
    endfunction

    function automatic logic [31:0] modelRead(input logic [4:0] a);
        case (a)
            5'd12: return mSr;
            5'd13: return mCause;
            5'd14: return mEpc;
            5'd15: return PRID;
            default: return 32'd0;
        endcase
    endfunction

    // Check outputs mid-cycle, advance one edge, then update the model
    task automatic stepCycle();
        logic taken;
        logic [31:0] expPc;
        logic [31:0] victim;
        #2;
        taken = modelInt() || modelExc();
        expPc = (!reset && !taken && modelRet()) ? mEpc : HANDLER;
        checkOutput("if_handler", {31'd0, ifHandler}, {31'd0, !reset && (taken || modelRet())});
        checkOutput("handler_pc", handlerPc, expPc);
        checkOutput("rdata", rdata, modelRead(addr));
        checkOutput("epc", epc, mEpc);
        @(posedge clk);
        if (reset) begin
            mSr = 0;
            mCause = 0;
            mEpc = 0;
        end else begin
            mCause[15:10] = hwInt;
            if (taken) begin
                if (!mSr[1]) begin
                    victim = bdM ? pcM - 4 : pcM;
                    mEpc = victim & 32'hFFFF_FFFC;
                    mCause[31] = bdM;
                end
                mCause[6:2] = modelInt() ? 5'd0 : excCodeM;
                mSr[1] = 1'b1;
            end else if (modelRet()) begin
                mSr[1] = 1'b0;
            end else if (we && addr == 5'd12) begin
                mSr = wdata & 32'h0000_FC03;
            end else if (we && addr == 5'd14) begin
                mEpc = wdata & 32'hFFFF_FFFC;
            end
        end
        #1;
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        mSr = 0;
        mCause = 0;
        mEpc = 0;
        applyStimulus(1, 1, 32'h3000, 0, 5'd4, 0, 6'h3F, 1, 5'd14, 32'h1234_5678);
        @(posedge clk);
        #1;
        stepCycle();

        // Reset values and PRId
        for (int a = 12; a <= 16; a++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, a[4:0], 0);
            stepCycle();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5'd15, 0);
        #1;
        checkOutput("prid", rdata, PRID);
        checkOutput("reset_if_handler", {31'd0, ifHandler}, 32'd0);

        // Enable IM[10] and IE, then take hw interrupt 0
        applyStimulus(0, 1, 32'h2000, 0, 0, 0, 0, 1, 5'd12, 32'h0000_0401);
        stepCycle();
        applyStimulus(0, 1, 32'h3010, 0, 0, 0, 6'h01, 1, 5'd14, 32'hFFFF_FFFF);
        #1;
        checkOutput("int_if_handler", {31'd0, ifHandler}, 32'd1);
        checkOutput("int_handler_pc", handlerPc, 32'h4180);
        stepCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5'd14, 0);
        #1;
        checkOutput("int_epc", rdata, 32'h3010);
        addr = 5'd13;
        #1;
        checkOutput("int_cause", rdata, 32'h0000_0400);
        addr = 5'd12;
        #1;
        checkOutput("int_sr", rdata, 32'h0000_0403);
        stepCycle();

        // eret back, then an address error in a delay slot
        applyStimulus(0, 1, 32'h4188, 0, 0, 1, 0, 0, 5'd12, 0);
        #1;
        checkOutput("eret_pc", handlerPc, 32'h3010);
        stepCycle();
        applyStimulus(0, 1, 32'h3024, 1, 5'd4, 0, 0, 0, 5'd13, 0);
        stepCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5'd13, 0);
        #1;
        checkOutput("adel_cause", rdata, 32'h8000_0010);
        checkOutput("adel_epc", epc, 32'h3020);
        stepCycle();

        // Nested RI while EXL=1, with a dropped mtc0 to SR
        applyStimulus(0, 1, 32'h4190, 0, 5'd10, 1, 0, 1, 5'd12, 0);
        #1;
        checkOutput("nested_pc", handlerPc, 32'h4180);
        stepCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5'd12, 0);
        #1;
        checkOutput("nested_sr", rdata, 32'h0000_0403);
        checkOutput("nested_epc", epc, 32'h3020);
        addr = 5'd13;
        #1;
        checkOutput("nested_cause", rdata, 32'h8000_0028);
        stepCycle();

        // eret clears EXL; interrupt waits through bubbles
        applyStimulus(0, 1, 32'h4194, 0, 0, 1, 0, 0, 5'd12, 0);
        #1;
        checkOutput("eret2_pc", handlerPc, 32'h3020);
        stepCycle();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 32'h5000, 0, 0, 0, 6'h01, 0, 5'd12, 0);
            #1;
            checkOutput("bubble_if_handler", {31'd0, ifHandler}, 32'd0);
            stepCycle();
        end
        applyStimulus(0, 1, 32'h5004, 0, 0, 0, 6'h01, 0, 5'd14, 0);
        #1;
        checkOutput("deferred_int", {31'd0, ifHandler}, 32'd1);
        stepCycle();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [4:0] code;
            logic [4:0] a;
            logic [31:0] d;
            case ($urandom_range(0, 9))
                0: code = 5'd4;
                1: code = 5'd10;
                2: code = ($urandom_range(0, 1) != 0) ? 5'd5 : 5'd12;
                default: code = 5'd0;
            endcase
            a = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(12, 15));
            d = $urandom;
            if ($urandom_range(0, 3) == 0) d[0] = 1'b1;
            applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 4) != 0, $urandom,
                          1'($urandom), code, $urandom_range(0, 4) == 0,
                          ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0,
                          $urandom_range(0, 2) == 0, a, d);
            stepCycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
